// File: rtl/sie_mode_pkg.sv
// Shared state type and mode constants for the SIE host/slave mode sequencer.
package sie_mode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GATE,
        ST_RESET,
        ST_SWITCH,
        ST_SETTLE
    } sie_mode_state_t;

    localparam logic SIE_MODE_SLAVE = 1'b0;
    localparam logic SIE_MODE_HOST  = 1'b1;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sie_quiet_detect.sv
// Counts consecutive cycles with the SIE idle and no write enables active;
// met is raised on the cycle whose sample completes a run of QUIET_CYCLES.
module sie_quiet_detect #(
    parameter int QUIET_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic quiet,
    output logic met
);

    localparam int CW = $clog2(QUIET_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(QUIET_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(QUIET_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !quiet) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Looks ahead one sample so the FSM leaves DRAIN on the edge that completes the run.
    assign met = !clear && quiet && (cnt_q >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sie_mode_sequencer.sv
// Sequences host/slave ownership changes of the shared SIE port (usbClk domain).
// Optional drain timeout and sticky drainTimedOut flag: define SIE_MODE_TIMEOUT_EN.
module sie_mode_sequencer
    import sie_mode_pkg::*;
#(
    parameter int QUIET_CYCLES  = 8,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic usbClk,
    input  logic rstN,
    input  logic modeReq,
    input  logic modeReqValid,
    output logic modeReqReady,
    input  logic sieBusy,
    input  logic SIEPortWEnFromHost,
    input  logic SIEPortWEnFromSlave,
    output logic wEnGate,
    output logic sieRst,
    output logic hostMode,
    output logic modeDone,
    output logic drainTimedOut,
    input  logic clrFlags
);

    localparam int CNT_MAX = max_of4(QUIET_CYCLES, RST_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT);
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LIMIT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    sie_mode_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            target_q, target_d;
    logic            host_mode_q, host_mode_d;
    logic            ready_q, ready_d;
    logic            wen_gate_q, wen_gate_d;
    logic            sie_rst_q, sie_rst_d;
    logic            mode_done_q, mode_done_d;
    logic            quiet;
    logic            quiet_met;
    logic            drain_clear;

    assign quiet       = !(sieBusy || SIEPortWEnFromHost || SIEPortWEnFromSlave);
    assign drain_clear = (state_q != ST_DRAIN);

    sie_quiet_detect #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet_detect (
        .clk  (usbClk),
        .rst_n(rstN),
        .clear(drain_clear),
        .quiet(quiet),
        .met  (quiet_met)
    );

`ifdef SIE_MODE_TIMEOUT_EN
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
    logic timed_out_q, timed_out_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
        target_d    = target_q;
        host_mode_d = host_mode_q;
        mode_done_d = 1'b0;
`ifdef SIE_MODE_TIMEOUT_EN
        timed_out_d = timed_out_q && !clrFlags;
`endif
        case (state_q)
            ST_IDLE: begin
                if (modeReqValid) begin
                    target_d = modeReq;
                    if (modeReq == host_mode_q) begin
                        mode_done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (quiet_met) begin
                    state_d = ST_GATE;
                end
`ifdef SIE_MODE_TIMEOUT_EN
                else if (cnt_q == DRAIN_LAST) begin
                    state_d     = ST_GATE;
                    timed_out_d = 1'b1;
                end
`endif
            end
            ST_GATE: begin
                state_d = ST_RESET;
            end
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = ST_SWITCH;
                    host_mode_d = target_q;
                end
            end
            ST_SWITCH: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = ST_IDLE;
                    mode_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
        // Outputs are decoded from the next state so they register alongside it.
        ready_d    = (state_d == ST_IDLE);
        wen_gate_d = (state_d == ST_GATE) || (state_d == ST_RESET) ||
                     (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
        sie_rst_d  = (state_d == ST_RESET);
    end

    always_ff @(posedge usbClk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            target_q    <= SIE_MODE_SLAVE;
            host_mode_q <= SIE_MODE_SLAVE;
            ready_q     <= 1'b1;
            wen_gate_q  <= 1'b0;
            sie_rst_q   <= 1'b0;
            mode_done_q <= 1'b0;
`ifdef SIE_MODE_TIMEOUT_EN
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            target_q    <= target_d;
            host_mode_q <= host_mode_d;
            ready_q     <= ready_d;
            wen_gate_q  <= wen_gate_d;
            sie_rst_q   <= sie_rst_d;
            mode_done_q <= mode_done_d;
`ifdef SIE_MODE_TIMEOUT_EN
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign modeReqReady = ready_q;
    assign wEnGate      = wen_gate_q;
    assign sieRst       = sie_rst_q;
    assign hostMode     = host_mode_q;
    assign modeDone     = mode_done_q;

`ifdef SIE_MODE_TIMEOUT_EN
    assign drainTimedOut = timed_out_q;
`else
    logic unused_clr_flags;
    assign unused_clr_flags = clrFlags;
    assign drainTimedOut    = 1'b0;
`endif

endmodule

// File: tb/tb_sie_mode_sequencer.sv
// Bench for sie_mode_sequencer: vector table, directed corner sequences and
// randomized transactions checked against a timeline model of the mode switch.
module tb_sie_mode_sequencer;
    import sie_mode_pkg::*;

    localparam int Q = 8;
    localparam int R = 4;
    localparam int S = 16;
    localparam int T = 1024;

    logic usbClk = 1'b0;
    logic rstN;
    logic modeReq, modeReqValid, sieBusy, SIEPortWEnFromHost, SIEPortWEnFromSlave, clrFlags;
    logic modeReqReady, wEnGate, sieRst, hostMode, modeDone, drainTimedOut;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic model_host = SIE_MODE_SLAVE;
    logic model_flag = 1'b0;

    typedef struct packed {
        logic       valid;
        logic       req;
        logic       busy;
        logic       wh;
        logic       ws;
        logic       clr;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 usbClk = ~usbClk;

    sie_mode_sequencer dut (
        .usbClk             (usbClk),
        .rstN               (rstN),
        .modeReq            (modeReq),
        .modeReqValid       (modeReqValid),
        .modeReqReady       (modeReqReady),
        .sieBusy            (sieBusy),
        .SIEPortWEnFromHost (SIEPortWEnFromHost),
        .SIEPortWEnFromSlave(SIEPortWEnFromSlave),
        .wEnGate            (wEnGate),
        .sieRst             (sieRst),
        .hostMode           (hostMode),
        .modeDone           (modeDone),
        .drainTimedOut      (drainTimedOut),
        .clrFlags           (clrFlags)
    );

    task automatic tick();
        @(posedge usbClk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic valid, input logic req, input logic busy,
                                 input logic wh, input logic ws, input logic clr);
        modeReqValid        = valid;
        modeReq             = req;
        sieBusy             = busy;
        SIEPortWEnFromHost  = wh;
        SIEPortWEnFromSlave = ws;
        clrFlags            = clr;
    endtask

    // Vector order: {ready, wEnGate, sieRst, hostMode, modeDone, drainTimedOut}
    task automatic checkOutput(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {modeReqReady, wEnGate, sieRst, hostMode, modeDone, drainTimedOut};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%b want=%b (ready,gate,rst,host,done,flag)",
                     name, cyc, got, exp);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic idleCycles(input int n);
        logic clr;
        for (int i = 0; i < n; i++) begin
            clr = 1'($urandom_range(1, 0));
            applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), clr);
            tick();
            if (clr) model_flag = 1'b0;
            checkOutput("idle", {1'b1, 1'b0, 1'b0, model_host, 1'b0, model_flag});
        end
    endtask

    // One request from acceptance in the current cycle to its modeDone. The model
    // finds the first run of Q quiet cycles after acceptance; every later phase is
    // a fixed offset from that gate cycle. Returns DUT-observed offsets.
    task automatic runTransaction(input logic req, input int pattern, input bit pre_driven,
                                  input bit hold_valid, input logic next_req,
                                  output int obs_done, output int obs_gate);
        int   a, gate, done, run, k, span;
        logic old_host, v, rq, b, wh, ws;
        bit   timed_out;
        old_host  = model_host;
        a         = cyc;
        gate      = -1;
        run       = 0;
        timed_out = 1'b0;
        obs_done  = -1;
        obs_gate  = -1;
        done      = (req == old_host) ? a + 1 : -1;
        span      = int'($urandom_range(40, 5));
        if (!pre_driven) applyStimulus(1'b1, req, 1'b0, 1'b0, 1'b0, 1'b0);
        forever begin
            tick();
            k = cyc - a;
            if (modeDone && obs_done < 0) obs_done = k;
            if (wEnGate && obs_gate < 0) obs_gate = k;
            if (gate >= 0 && cyc == gate && timed_out) model_flag = 1'b1;
            if (cyc == done) begin
                model_host = req;
                checkOutput("doneCycle", {1'b1, 1'b0, 1'b0, req, 1'b1, model_flag});
                applyStimulus(hold_valid, next_req, 1'b0, 1'b0, 1'b0, 1'b0);
                break;
            end
            checkOutput("inFlight", {1'b0, (gate >= 0 && cyc >= gate),
                                     (gate >= 0 && cyc > gate && cyc <= gate + R),
                                     ((gate >= 0 && cyc > gate + R) ? req : old_host),
                                     1'b0, model_flag});
            v  = hold_valid;
            rq = k[0];
            if (pattern == 2 && !hold_valid) begin
                v  = 1'($urandom_range(1, 0));
                rq = 1'($urandom_range(1, 0));
            end
            b  = 1'b0;
            wh = 1'b0;
            ws = 1'b0;
            if (gate < 0) begin
                case (pattern)
                    1: b = (k % 5 == 0) && (k <= 50);
                    2: if (k <= span) begin
                        b  = ($urandom_range(3, 0) == 0);
                        wh = ($urandom_range(5, 0) == 0);
                        ws = ($urandom_range(5, 0) == 0);
                    end
                    3: b = 1'b1;
                    default: ;
                endcase
            end else if (pattern == 2) begin
                b  = 1'($urandom_range(1, 0));
                wh = 1'($urandom_range(1, 0));
                ws = 1'($urandom_range(1, 0));
            end
            applyStimulus(v, rq, b, wh, ws, 1'b0);
            if (gate < 0) begin
                run = (b || wh || ws) ? 0 : run + 1;
                if (run >= Q) begin
                    gate = cyc + 1;
                end
`ifdef SIE_MODE_TIMEOUT_EN
                else if (k == T) begin
                    gate      = cyc + 1;
                    timed_out = 1'b1;
                end
`endif
                if (gate >= 0) done = gate + R + S + 2;
            end
        end
    endtask

    initial begin
        int a, lat, g, lat2, g2, pulses;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b100010};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b100010};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'b100000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b100000};

        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("resetState", 6'b100000);
        rstN = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].req, vecs[i].busy,
                          vecs[i].wh, vecs[i].ws, vecs[i].clr);
            tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        $display("[TB] host request with idle SIE");
        runTransaction(SIE_MODE_HOST, 0, 1'b0, 1'b0, 1'b0, lat, g);
        checkValue("hostLatency", lat, 1 + Q + 1 + R + 1 + S);
        checkValue("hostGateOffset", g, Q + 1);
        idleCycles(3);

        $display("[TB] reset asserted during RESET");
        applyStimulus(1'b1, SIE_MODE_SLAVE, 1'b0, 1'b0, 1'b0, 1'b0);
        a = cyc;
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (cyc < a + Q + 3) tick();
        checkOutput("midReset", {1'b0, 1'b1, 1'b1, SIE_MODE_HOST, 1'b0, model_flag});
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("asyncReset", 6'b100000);
        model_host = SIE_MODE_SLAVE;
        model_flag = 1'b0;
        tick();
        tick();
        rstN   = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (modeDone) pulses++;
        end
        checkValue("noDoneAfterReset", pulses, 0);
        checkOutput("idleAfterReset", 6'b100000);

        $display("[TB] busy pulse every 5 cycles");
        runTransaction(SIE_MODE_HOST, 1, 1'b0, 1'b0, 1'b0, lat, g);
        checkValue("busyGateOffset", g, 50 + Q + 1);

        $display("[TB] valid held through SETTLE");
        idleCycles(2);
        runTransaction(SIE_MODE_SLAVE, 0, 1'b0, 1'b1, SIE_MODE_HOST, lat, g);
        checkValue("heldLatency", lat, 1 + Q + 1 + R + 1 + S);
        runTransaction(SIE_MODE_HOST, 0, 1'b1, 1'b0, 1'b0, lat2, g2);
        checkValue("chainedLatency", lat2, 1 + Q + 1 + R + 1 + S);

`ifdef SIE_MODE_TIMEOUT_EN
        $display("[TB] drain timeout");
        idleCycles(1);
        runTransaction(!model_host, 3, 1'b0, 1'b0, 1'b0, lat, g);
        checkValue("timeoutGateOffset", g, T + 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flagSticky", {1'b1, 1'b0, 1'b0, model_host, 1'b0, 1'b1});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        model_flag = 1'b0;
        checkOutput("flagCleared", {1'b1, 1'b0, 1'b0, model_host, 1'b0, 1'b0});
`endif

        $display("[TB] randomized transactions");
        for (int i = 0; i < 20; i++) begin
            idleCycles(int'($urandom_range(3, 0)));
            runTransaction(1'($urandom_range(1, 0)), 2, 1'b0, 1'b0, 1'b0, lat, g);
        end
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
